pram_arb: RTL and testbench
===========================

PRAM_ARB -- requirements
Module: pram_arb

Interface
REQ-001 SHALL have parameter data_wl, default 16, pram data word width.
REQ-002 SHALL have parameter adr_wl, default 12, pram address width.
REQ-003 SHALL have parameter lock_max, default 8, max consecutive locked grants to one requester (range 2..255).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 a_reset  input  1  reset, asynchronous, active-high.
REQ-006 req0, req1  input  1 each  access request, requester 0 = init loader, 1 = fetch.
REQ-007 we0, we1  input  1 each  1 = write, 0 = read; valid while reqN high.
REQ-008 lock0, lock1  input  1 each  keep ownership for next access.
REQ-009 adr0, adr1  input  adr_wl each  access address.
REQ-010 wdata0, wdata1  input  data_wl each  write data.
REQ-011 gnt0, gnt1  output  1 each  access accepted this cycle.
REQ-012 rvalid0, rvalid1  output  1 each  read data valid for that requester.
REQ-013 rdata  output  data_wl  read data, shared, qualified by rvalidN.
REQ-014 pram_cs, pram_we  output  1 each  pram chip select / write enable.
REQ-015 pram_adr  output  adr_wl; pram_wdata  output  data_wl  pram address / write data.
REQ-016 pram_rdata  input  data_wl  synchronous pram read data (valid one cycle after read edge).

Function
REQ-017 SHALL keep FSM states IDLE, OWN0, OWN1; at most one gntN high per cycle.
REQ-018 gntN, pram_cs, pram_we, pram_adr, pram_wdata SHALL be combinational from state and requests; pram_cs = gnt0|gnt1; pram_we/adr/wdata = granted requester's we/adr/wdata; zero when no grant.
REQ-019 In IDLE: single requester SHALL be granted same cycle; both requesting SHALL resolve by policy (REQ-030/031).
REQ-020 Grant with lockN=1 SHALL move FSM to OWNN; grant with lockN=0 SHALL move to IDLE and update last-winner pointer.
REQ-021 In OWNN: reqN=1 SHALL be granted regardless of other request; reqN=0 SHALL release to IDLE with no grant that cycle to either requester.
REQ-022 Lock counter SHALL count consecutive grants in OWNN; at the lock_max-th grant the FSM SHALL return to IDLE with pointer set to N, even if lockN=1.
REQ-023 If other requester is idle at lock_max, re-entry to OWNN on next cycle SHALL be allowed (one-cycle IDLE pass, no grant loss beyond normal IDLE arbitration).
REQ-024 rvalidN SHALL assert exactly one cycle after a read grant (gntN & ~weN), rdata = pram_rdata in that cycle; writes SHALL produce no rvalid.
REQ-025 Back-to-back reads SHALL give back-to-back rvalid pulses, order preserved; rvalid0 and rvalid1 SHALL never be high together.
REQ-026 reqN dropped without gnt SHALL be legal; no state change for that requester.

Reset
REQ-027 a_reset high SHALL immediately force FSM IDLE, lock counter 0, pointer to requester 1 (so requester 0 wins first tie), rvalid0/rvalid1 0.
REQ-028 Outputs during reset: gnt0/gnt1/pram_cs/pram_we 0, pram_adr/pram_wdata/rdata 0.
REQ-029 Read granted in cycle of reset assertion SHALL not produce rvalid after reset release.

Configuration
REQ-030 With PRAM_ARB_RR_EN defined: IDLE tie SHALL go to requester not equal to last-winner pointer (round robin).
REQ-031 Without PRAM_ARB_RR_EN: IDLE tie SHALL always go to requester 0 (fixed priority); pointer still maintained but unused; lock_max limit still applies.

Verification
REQ-032 Reset, then req1 read adr 0x010 -> gnt1 same cycle, pram_cs=1 pram_we=0 pram_adr=0x010; next cycle rvalid1=1, rdata=mem[0x010].
REQ-033 req0 write adr 0x005 data 0xBEEF, next cycle req1 read 0x005 -> rvalid1 with rdata=0xBEEF.
REQ-034 Both req constant, lock=0, RR_EN defined -> grants alternate 0,1,0,1; RR_EN undefined -> gnt0 every cycle, gnt1 never.
REQ-035 req0 with lock0=1 for 20 cycles, req1 high, lock_max=8 -> 8 consecutive gnt0, one IDLE cycle granting req1 (RR) then requester 0 regains.
REQ-036 a_reset asserted mid-burst in OWN0 after read grant -> outputs 0 asynchronously, no rvalid0 after release, first tie grants requester 0.

Source files
------------

// File: rtl/pram_arb.sv
// pram_arb: two-requester arbiter (0 = init loader, 1 = fetch) in front of a single-port sync PRAM.
// Define PRAM_ARB_RR_EN for round-robin IDLE ties; otherwise requester 0 always wins ties.
module pram_arb #(
    parameter int data_wl  = 16,
    parameter int adr_wl   = 12,
    parameter int lock_max = 8
) (
    input  logic               clk,
    input  logic               a_reset,
    input  logic               req0,
    input  logic               req1,
    input  logic               we0,
    input  logic               we1,
    input  logic               lock0,
    input  logic               lock1,
    input  logic [adr_wl-1:0]  adr0,
    input  logic [adr_wl-1:0]  adr1,
    input  logic [data_wl-1:0] wdata0,
    input  logic [data_wl-1:0] wdata1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               rvalid0,
    output logic               rvalid1,
    output logic [data_wl-1:0] rdata,
    output logic               pram_cs,
    output logic               pram_we,
    output logic [adr_wl-1:0]  pram_adr,
    output logic [data_wl-1:0] pram_wdata,
    input  logic [data_wl-1:0] pram_rdata
);

    localparam logic [7:0] LOCK_MAX = lock_max[7:0];

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state, state_nxt;
    logic [7:0] lock_cnt, lock_cnt_nxt, cnt_inc;
    logic       ptr, ptr_nxt;
    logic       lock_g;

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            state    <= IDLE;
            lock_cnt <= '0;
            ptr      <= 1'b1;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            ptr      <= ptr_nxt;
            rvalid0  <= gnt0 & ~we0;
            rvalid1  <= gnt1 & ~we1;
        end
    end

    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        ptr_nxt      = ptr;
        cnt_inc      = 8'd1;
        lock_g       = 1'b0;
        if (!a_reset) begin
            case (state)
                IDLE: begin
                    if (req0 && req1) begin
`ifdef PRAM_ARB_RR_EN
                        // ptr holds the last winner; the other side gets the tie
                        gnt0 = ptr;
                        gnt1 = ~ptr;
`else
                        gnt0 = 1'b1;
`endif
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                OWN0: gnt0 = req0;
                OWN1: gnt1 = req1;
                default: ;
            endcase

            if (gnt0 || gnt1) begin
                ptr_nxt = gnt1;
                lock_g  = gnt0 ? lock0 : lock1;
                // the grant that first takes ownership counts as grant one of the run
                cnt_inc = (state == IDLE) ? 8'd1 : lock_cnt + 8'd1;
                if (lock_g && (cnt_inc < LOCK_MAX)) begin
                    state_nxt    = gnt0 ? OWN0 : OWN1;
                    lock_cnt_nxt = cnt_inc;
                end else begin
                    state_nxt    = IDLE;
                    lock_cnt_nxt = '0;
                end
            end else if (state != IDLE) begin
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
            end
        end
    end

    assign pram_cs    = gnt0 | gnt1;
    assign pram_we    = gnt0 ? we0    : (gnt1 ? we1    : 1'b0);
    assign pram_adr   = gnt0 ? adr0   : (gnt1 ? adr1   : '0);
    assign pram_wdata = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);
    assign rdata      = (rvalid0 | rvalid1) ? pram_rdata : '0;

endmodule

// File: tb/tb_pram_arb.sv
// Bench for pram_arb: behavioural PRAM + arbitration model checked every cycle, plus directed literal checks.
module tb_pram_arb;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int LOCK_MAX = 8;

    logic          clk = 1'b0;
    logic          a_reset;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] adr0, adr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          pram_cs, pram_we;
    logic [AW-1:0] pram_adr;
    logic [DW-1:0] pram_wdata;
    logic [DW-1:0] pram_rdata;

    int vectors = 0;
    int miscompares = 0;

    pram_arb #(.data_wl(DW), .adr_wl(AW), .lock_max(LOCK_MAX)) dut (
        .clk(clk), .a_reset(a_reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .adr0(adr0), .adr1(adr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .pram_cs(pram_cs), .pram_we(pram_we),
        .pram_adr(pram_adr), .pram_wdata(pram_wdata), .pram_rdata(pram_rdata)
    );

    always #5 clk = ~clk;

    // PRAM behaviour: synchronous read, write on edge
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (pram_cs) begin
            if (pram_we) mem[pram_adr] <= pram_wdata;
            else         pram_rdata    <= mem[pram_adr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the PRAM, how long the current run is, who won last, what read is in flight
    int            m_owner, m_run, m_last, e_g;
    logic          m_rv0, m_rv1;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    logic          m_lk, m_we;
    logic [AW-1:0] m_a;

    initial begin
        e_g = -1; m_owner = -1; m_run = 0; m_last = 1;
        m_rv0 = 1'b0; m_rv1 = 1'b0; m_rdata = '0;
    end

    always @(negedge clk) begin
        e_g = -1;
        if (!a_reset) begin
            if (m_owner == 0)      e_g = req0 ? 0 : -1;
            else if (m_owner == 1) e_g = req1 ? 1 : -1;
            else if (req0 && req1) begin
`ifdef PRAM_ARB_RR_EN
                e_g = (m_last == 0) ? 1 : 0;
`else
                e_g = 0;
`endif
            end
            else if (req0) e_g = 0;
            else if (req1) e_g = 1;
        end
        chk("gnt0", 32'(gnt0), 32'(e_g == 0));
        chk("gnt1", 32'(gnt1), 32'(e_g == 1));
        chk("pram_cs", 32'(pram_cs), 32'(e_g >= 0));
        chk("pram_we", 32'(pram_we), (e_g == 0) ? 32'(we0) : (e_g == 1) ? 32'(we1) : 32'd0);
        chk("pram_adr", 32'(pram_adr), (e_g == 0) ? 32'(adr0) : (e_g == 1) ? 32'(adr1) : 32'd0);
        chk("pram_wdata", 32'(pram_wdata), (e_g == 0) ? 32'(wdata0) : (e_g == 1) ? 32'(wdata1) : 32'd0);
        chk("rvalid0", 32'(rvalid0), 32'(m_rv0));
        chk("rvalid1", 32'(rvalid1), 32'(m_rv1));
        chk("rdata", 32'(rdata), (m_rv0 || m_rv1) ? 32'(m_rdata) : 32'd0);
    end

    always @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            m_owner = -1; m_run = 0; m_last = 1; m_rv0 = 1'b0; m_rv1 = 1'b0;
        end else begin
            m_rv0 = (e_g == 0) && !we0;
            m_rv1 = (e_g == 1) && !we1;
            if (e_g >= 0) begin
                m_a  = (e_g == 0) ? adr0  : adr1;
                m_we = (e_g == 0) ? we0   : we1;
                m_lk = (e_g == 0) ? lock0 : lock1;
                if (m_we) m_mem[m_a] = (e_g == 0) ? wdata0 : wdata1;
                else      m_rdata = m_mem[m_a];
                m_run  = (m_owner == e_g) ? m_run + 1 : 1;
                m_last = e_g;
                if (m_lk && m_run < LOCK_MAX) m_owner = e_g;
                else begin m_owner = -1; m_run = 0; end
            end else begin
                m_owner = -1; m_run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]   = 16'(i) ^ 16'hA5A5;
            m_mem[i] = 16'(i) ^ 16'hA5A5;
        end
        a_reset = 1'b1;
        req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        adr0 = 12'h123; adr1 = '0; wdata0 = 16'h1111; wdata1 = '0;

        // reset: outputs held at zero even with a request pending
        repeat (2) @(posedge clk); #1;
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_cs", 32'(pram_cs), 32'd0);
        chk("rst_adr", 32'(pram_adr), 32'd0);
        chk("rst_wdata", 32'(pram_wdata), 32'd0);
        chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        a_reset = 1'b0; req0 = 1'b0; adr0 = '0; wdata0 = '0;
        tick();

        // single read by requester 1
        req1 = 1'b1; adr1 = 12'h010;
        @(negedge clk);
        chk("t1_gnt1", 32'(gnt1), 32'd1);
        chk("t1_cs_we", 32'({pram_cs, pram_we}), 32'b10);
        chk("t1_adr", 32'(pram_adr), 32'h010);
        tick(); req1 = 1'b0;
        @(negedge clk);
        chk("t1_rvalid1", 32'(rvalid1), 32'd1);
        chk("t1_rdata", 32'(rdata), 32'hA5B5);
        tick();

        // write by 0, read back by 1
        req0 = 1'b1; we0 = 1'b1; adr0 = 12'h005; wdata0 = 16'hBEEF;
        @(negedge clk);
        chk("t2_gnt0", 32'(gnt0), 32'd1);
        chk("t2_we", 32'(pram_we), 32'd1);
        chk("t2_wdata", 32'(pram_wdata), 32'hBEEF);
        tick(); req0 = 1'b0; we0 = 1'b0; wdata0 = '0;
        req1 = 1'b1; adr1 = 12'h005;
        tick(); req1 = 1'b0;
        @(negedge clk);
        chk("t2_rvalid0", 32'(rvalid0), 32'd0);
        chk("t2_rdata", 32'(rdata), 32'hBEEF);
        tick();

        // constant tie, no lock
        req0 = 1'b1; req1 = 1'b1; adr0 = 12'h020; adr1 = 12'h030;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
`ifdef PRAM_ARB_RR_EN
            chk("t3_gnt1", 32'(gnt1), 32'(c % 2));
            chk("t3_gnt0", 32'(gnt0), 32'(1 - c % 2));
`else
            chk("t3_gnt1", 32'(gnt1), 32'd0);
            chk("t3_gnt0", 32'(gnt0), 32'd1);
`endif
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // locked burst by 0 against a constant request from 1
        req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1; adr1 = 12'h200;
        for (int c = 0; c < 20; c++) begin
            adr0 = 12'(12'h100 + c);
            @(negedge clk);
`ifdef PRAM_ARB_RR_EN
            chk("t4_gnt1", 32'(gnt1), 32'(c == 8 || c == 17));
            chk("t4_gnt0", 32'(gnt0), 32'(!(c == 8 || c == 17)));
`else
            chk("t4_gnt1", 32'(gnt1), 32'd0);
            chk("t4_gnt0", 32'(gnt0), 32'd1);
`endif
            @(posedge clk); #1;
        end
        // owner drops its request: one idle cycle, no grant to the waiter
        req0 = 1'b0; lock0 = 1'b0;
        @(negedge clk);
        chk("t4_rel_gnt", 32'({gnt0, gnt1}), 32'd0);
        tick();
        @(negedge clk);
        chk("t4_after_gnt1", 32'(gnt1), 32'd1);
        tick(); req1 = 1'b0;
        tick();

        // async reset in the middle of a locked read burst
        req0 = 1'b1; lock0 = 1'b1; adr0 = 12'h040;
        @(negedge clk);
        chk("t5_gnt0", 32'(gnt0), 32'd1);
        tick(); adr0 = 12'h041;
        #2 a_reset = 1'b1;
        #1;
        chk("t5_async_gnt0", 32'(gnt0), 32'd0);
        chk("t5_async_cs", 32'(pram_cs), 32'd0);
        chk("t5_async_adr", 32'(pram_adr), 32'd0);
        chk("t5_async_rvalid0", 32'(rvalid0), 32'd0);
        chk("t5_async_rdata", 32'(rdata), 32'd0);
        repeat (2) @(posedge clk); #1;
        a_reset = 1'b0; req0 = 1'b0; lock0 = 1'b0;
        @(negedge clk);
        chk("t5_no_rvalid0", 32'(rvalid0), 32'd0);
        tick();
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        chk("t5_tie_gnt0", 32'(gnt0), 32'd1);
        chk("t5_tie_gnt1", 32'(gnt1), 32'd0);
        tick(); req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
